// File: rtl/shifter_ctrl_if.sv
// Bundle of the reconfiguration request port, the upstream/shifter stream handshakes
// and the shifter control lines that the sequencing controller owns.
interface shifter_ctrl_if #(
    parameter int DW = 32
);
    // Handshakes are strict valid/ready: a transfer happens on a rising clk edge where
    // valid and ready are both high; valid never waits on ready, and a source holds its
    // data stable until that transfer. cfg_wr is a single-cycle strobe with no ready.
    logic          cfg_wr;
    logic [DW-1:0] cfg_wmask;
    logic          cfg_wena;
    logic          cfg_busy;
    logic          cfg_drop;
    logic          drain_err;
    logic          src_valid;
    logic          src_ready;
    logic          sti_valid;
    logic          sti_ready;
    logic          sto_valid;
    logic          sto_ready;
    logic          ctl_ena;
    logic          ctl_clr;
    logic [DW-1:0] cfg_mask;

    modport master (
        input  cfg_wr, cfg_wmask, cfg_wena, src_valid, sti_ready, sto_valid, sto_ready,
        output cfg_busy, cfg_drop, drain_err, src_ready, sti_valid, ctl_ena, ctl_clr, cfg_mask
    );

    modport slave (
        output cfg_wr, cfg_wmask, cfg_wena, src_valid, sti_ready, sto_valid, sto_ready,
        input  cfg_busy, cfg_drop, drain_err, src_ready, sti_valid, ctl_ena, ctl_clr, cfg_mask
    );
endinterface

// File: rtl/shifter_ctrl.sv
// Sequencing controller for the bit-compaction shifter: gates input, drains the
// pipeline, clears it and loads a new mask whenever a reconfiguration is requested.
module shifter_ctrl #(
    parameter int DW        = 32,
    parameter int DL        = $clog2(DW),
    parameter int DRAIN_MAX = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    shifter_ctrl_if.master       bus,
    output logic [2:0]           dbg_state,
    output logic [$clog2(DL+1):0] dbg_occ
);
    localparam int OW = $clog2(DL + 1) + 1;
    localparam int CW = $clog2(DRAIN_MAX + 1);

    // Encoding is fixed so debug probes can decode dbg_state directly.
    typedef enum logic [2:0] {
        BYPASS = 3'd0,
        RUN    = 3'd1,
        DRAIN  = 3'd2,
        CLEAR  = 3'd3,
        LOAD   = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [DW-1:0] mask_q, pend_mask;
    logic          pend_ena, rec_mode, drop_q, err_q;
    logic [CW-1:0] drain_cnt;
    logic [OW-1:0] occ;
    logic          pass, busy, drain_timeout, inc, dec, occ_clr;

    assign pass          = (state == BYPASS) || (state == RUN);
    assign busy          = (state == DRAIN) || (state == CLEAR) || (state == LOAD);
    assign drain_timeout = (state == DRAIN) && (occ != '0) && (drain_cnt == CW'(DRAIN_MAX - 1));

    assign bus.sti_valid = pass & bus.src_valid;
    assign bus.src_ready = pass & bus.sti_ready;
    assign bus.ctl_ena   = (state == RUN) || ((state == DRAIN) && rec_mode);
    assign bus.ctl_clr   = (state == CLEAR);
    assign bus.cfg_busy  = busy;
    assign bus.cfg_drop  = drop_q;
    assign bus.drain_err = err_q;
    assign bus.cfg_mask  = mask_q;
    assign dbg_state     = state;
    assign dbg_occ       = occ;

    assign inc     = bus.sti_valid & bus.sti_ready & bus.ctl_ena;
    assign dec     = bus.sto_valid & bus.sto_ready & bus.ctl_ena;
    // Cleared already on the way into CLEAR so the counter reads zero during CLEAR.
    assign occ_clr = (state_next == CLEAR) || (state == CLEAR) || (state == BYPASS);

    always_comb begin
        state_next = state;
        case (state)
            BYPASS, RUN: if (bus.cfg_wr) state_next = DRAIN;
            DRAIN:       if ((occ == '0) || drain_timeout) state_next = CLEAR;
            CLEAR:       state_next = LOAD;
            LOAD:        state_next = (pend_ena && (pend_mask != '0)) ? RUN : BYPASS;
            default:     state_next = BYPASS;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BYPASS;
            mask_q    <= '1;
            pend_mask <= '0;
            pend_ena  <= 1'b0;
            rec_mode  <= 1'b0;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
            drain_cnt <= '0;
            occ       <= '0;
        end else begin
            state  <= state_next;
            drop_q <= busy & bus.cfg_wr;
            err_q  <= err_q | drain_timeout;
            if (state == CLEAR) mask_q <= pend_mask;
            if (pass && bus.cfg_wr) begin
                pend_mask <= bus.cfg_wmask;
                pend_ena  <= bus.cfg_wena;
                rec_mode  <= (state == RUN);
            end
            if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
            else                drain_cnt <= '0;
            if (occ_clr)                                occ <= '0;
            else if (inc && !dec && (occ != {OW{1'b1}})) occ <= occ + 1'b1;
            else if (dec && !inc && (occ != '0))         occ <= occ - 1'b1;
        end
    end
endmodule

// File: doc/shifter_ctrl.md
# shifter_ctrl

Sequencing controller for the bit-compaction shifter in the capture datapath. Sits in front of the shifter's input stream and owns its `ctl_ena`, `ctl_clr` and `cfg_mask` inputs. Accepts reconfiguration requests (new mask, run/bypass mode) and applies them without corrupting samples. Before switching, it gates new input, drains the shifter pipeline, clears it and loads the new mask.

## Interface
- `DW`, 32: data/mask width; must match the shifter.
- `DL`, clog2(DW): shifter pipeline depth in cycles; sizes the occupancy counter.
- `DRAIN_MAX`, 64: drain timeout in cycles, ≥ DL+1.

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `cfg_wr`  in  1  one-cycle reconfiguration request
- `cfg_wmask`  in  DW  requested mask
- `cfg_wena`  in  1  requested mode: 1 = run (compaction on), 0 = bypass
- `cfg_busy`  out  1  reconfiguration in progress
- `cfg_drop`  out  1  one-cycle pulse: `cfg_wr` ignored because busy
- `drain_err`  out  1  sticky: drain timed out, pipeline contents discarded; cleared only by `rst`
- `src_valid`  in  1  upstream stream valid
- `src_ready`  out  1  upstream stream ready
- `sti_valid`  out  1  shifter input valid
- `sti_ready`  in  1  shifter input ready
- `sto_valid`  in  1  shifter output valid (monitored)
- `sto_ready`  in  1  shifter output ready (monitored)
- `ctl_ena`  out  1  shifter enable
- `ctl_clr`  out  1  shifter pipeline clear
- `cfg_mask`  out  DW  mask applied to the shifter

## Operation
- States: `BYPASS`, `RUN`, `DRAIN`, `CLEAR`, `LOAD`. Outputs are Moore-decoded from the registered state, except the stream pass-through.
- Reset values: state `BYPASS`, `cfg_mask` = all ones, `ctl_ena` = 0, `ctl_clr` = 0, `cfg_busy` = 0, `cfg_drop` = 0, `drain_err` = 0, occupancy = 0, pending registers = 0.
- **`BYPASS` / `RUN`:**
  - `sti_valid = src_valid` and `src_ready = sti_ready`.
  - `ctl_ena` = 0 in `BYPASS`, 1 in `RUN`.
  - `cfg_wr` latches `cfg_wmask` and `cfg_wena` into pending registers, records the current mode bit, and moves to `DRAIN`.
- **`DRAIN`:**
  - `src_ready` = 0 and `sti_valid` = 0.
  - `ctl_ena` holds the recorded mode bit, so the pipeline keeps moving.
  - Move to `CLEAR` when occupancy == 0.
  - Otherwise move to `CLEAR` once `DRAIN_MAX` cycles have elapsed in `DRAIN`, and set `drain_err`.
- **`CLEAR`:** one cycle; `ctl_clr` = 1, `ctl_ena` = 0, input gated.
- **`LOAD`:**
  - One cycle; `ctl_ena` = 0, input gated.
  - `cfg_mask` takes the pending mask on entry, so it is visible during `LOAD`.
  - Next state is `RUN` if the pending mode bit is 1 and the pending mask is nonzero, else `BYPASS`.
  - An all-zero mask always forces `BYPASS`.
- `cfg_busy` = 1 exactly in `DRAIN`, `CLEAR` and `LOAD`.
- `cfg_wr` while busy is ignored: pending registers are unchanged and `cfg_drop` pulses the following cycle.
- **Occupancy counter** (width clog2(DL+1)+1, saturating at both ends):
  - +1 on `sti_valid & sti_ready` while `ctl_ena` = 1.
  - −1 on `sto_valid & sto_ready` while `ctl_ena` = 1.
  - Both in the same cycle: no change.
  - Forced to 0 in `CLEAR` and `BYPASS`.
- `rst` asserted mid-operation returns everything to reset values immediately. A pending request is lost.

## Timing
- `cfg_wr` is sampled at edge N:
  - `DRAIN` at N+1.
  - With occupancy 0: `CLEAR` at N+2, `LOAD` (new mask) at N+3, final state with `cfg_busy` = 0 at N+4.
- With occupancy k > 0 and `sto_ready` held high, `DRAIN` lasts until the cycle after the last output transfer.
- `src_ready` falls combinationally in the first `DRAIN` cycle and returns in the first `RUN`/`BYPASS` cycle.
- `ctl_clr` is high for exactly 1 cycle per reconfiguration.
- `cfg_mask` never changes while `ctl_ena` = 1.

## Test plan
- **Reset:** assert `rst` asynchronously mid-`DRAIN` → all outputs at reset values within the same cycle; `cfg_mask` = 0xFFFFFFFF.
- **Bypass to run, empty pipeline:** in `BYPASS`, `cfg_wr` with mask 0x0000FF0F, ena=1 at edge N → `busy` high N+1..N+3, `ctl_clr` high at N+2, `cfg_mask` = 0x0000FF0F at N+3, `ctl_ena` = 1 at N+4.
- **Drain with data in flight:** in `RUN`, 3 samples in flight, `sto_ready` = 1 → `src_ready` = 0 during drain; exactly 3 outputs emerge; `CLEAR` follows the cycle after the last transfer.
- **Drain timeout:** `sto_ready` = 0, occupancy 2, `DRAIN_MAX` = 64 → `CLEAR` after 64 `DRAIN` cycles, `drain_err` = 1 and sticky, occupancy 0.
- **Request while busy:** second `cfg_wr` during `LOAD` → `cfg_drop` pulses one cycle; the final mask is from the first request.
- **Zero mask:** `cfg_wr` with mask 0, ena=1 → ends in `BYPASS`, `ctl_ena` = 0.
